// File: rtl/ps2_key_encoder_pkg.sv
// Shared types and tables for the PS/2 key encoder: FSM state enum,
// the 16-entry scan-code table and the per-index extended-key flags.
package ps2_key_encoder_pkg;

  typedef enum logic {
    SCAN = 1'b0,
    GAP  = 1'b1
  } state_t;

  // Scan codes by button index; element 0 is the rightmost entry.
  localparam logic [15:0][7:0] SCAN_CODE = {
    8'h23, 8'h2B, 8'h2D, 8'h3D, 8'h36, 8'h1E, 8'h2E, 8'h16,
    8'h12, 8'h14, 8'h11, 8'h29, 8'h75, 8'h72, 8'h6B, 8'h74
  };

  // Extended (E0-prefixed) keys: the four cursor keys at indices 0-3.
  localparam logic [15:0] EXT_FLAG = 16'h000F;

endpackage

// File: rtl/ps2_key_encoder_gap_timer.sv
// Down-counter that spaces successive key events: loaded when an event is
// emitted, decremented while the encoder waits, and reports zero.
module ps2_key_encoder_gap_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load takes priority over decrement; the count parks at zero.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 key encoder: scans a 16-button bitmap round-robin and emits one
// ps2_key event (toggle/pressed/extended/code) per changed button, with at
// least GAP_CYCLES clocks between events.
// Optional feature macro: PS2_KEY_ENCODER_EXTENDED_EN drives ps2_key[8]
// from the extended-flag table; otherwise ps2_key[8] stays 0.
module ps2_key_encoder
  import ps2_key_encoder_pkg::*;
#(
  parameter int GAP_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] btn,
  input  logic        enable,
  output logic [10:0] ps2_key,
  output logic        busy,
  output logic        pending
);

  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_rpt;
  logic [3:0]  r_idx;
  logic [10:0] r_key;
  logic        w_btn_bit;
  logic        w_event;
  logic        w_ext;
  logic        w_gap_zero;

  assign w_btn_bit = btn[r_idx];
  assign w_event   = (r_state == SCAN) && enable && (w_btn_bit != r_rpt[r_idx]);

`ifdef PS2_KEY_ENCODER_EXTENDED_EN
  assign w_ext = EXT_FLAG[r_idx];
`else
  assign w_ext = 1'b0;
`endif

  ps2_key_encoder_gap_timer #(
    .CNT_W(16)
  ) u_gap_timer (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .i_load    (w_event),
    .i_load_val(GAP_LOAD),
    .i_dec     (r_state == GAP),
    .o_zero    (w_gap_zero)
  );

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= SCAN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: leave SCAN on an event, leave GAP once the timer reads zero.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SCAN:    if (w_event)    w_state_nxt = GAP;
      GAP:     if (w_gap_zero) w_state_nxt = SCAN;
      default: w_state_nxt = SCAN;
    endcase
  end

  // Reported state, scan index and event output. With enable low the
  // reported state tracks btn so that re-enabling raises no stale events.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_rpt <= '0;
      r_idx <= '0;
      r_key <= '0;
    end else begin
      if (!enable) begin
        r_rpt <= btn;
      end else if (w_event) begin
        r_rpt[r_idx] <= w_btn_bit;
        r_key        <= {~r_key[10], w_btn_bit, w_ext, SCAN_CODE[r_idx]};
      end
      if (enable && (r_state == SCAN)) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign ps2_key = r_key;
  assign busy    = (r_state == GAP);
  assign pending = |(btn ^ r_rpt);

endmodule
